// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- bundles the instruction-fetch handshake and the
// execute-stage control/operand signals of the PC sequencer.
//   master : the sequencer (drives fetch request, instr, pc, trap flags)
//   slave  : instruction memory plus execute stage (drives ready/rdata,
//            retire and the next-PC select inputs)
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        is_branch;
  logic        taken;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        misalign;
  logic [31:0] trap_addr;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           misalign, trap_addr,
    input  imem_ready, imem_rdata, retire, is_branch, taken, is_jal,
           is_jalr, imm, rs1
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           misalign, trap_addr,
    output imem_ready, imem_rdata, retire, is_branch, taken, is_jal,
           is_jalr, imm, rs1
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer: fetches one instruction,
// holds it until the execute stage retires it, then selects the next PC
// (jalr > jal > taken branch > pc+4). A target with bit 1 set parks the
// block in a terminal trap state with the offending address captured.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pc_sequencer_if.master (fetch handshake, instr/pc outputs,
//            retire and next-PC select inputs, misalign/trap_addr)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BOOT  | post-reset settling; one full cycle before the first fetch
// ST_FETCH | imem_req high, waiting for imem_ready
// ST_EXEC  | instr valid, waiting for retire to pick the next pc
// ST_TRAP  | misaligned target seen; terminal until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_sequencer_if.master    bus
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        boot_q, boot_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] target;

  always_comb begin
    target = pc_q + 32'd4;
    if (bus.is_jalr) begin
      target = (bus.rs1 + bus.imm) & ~32'h1;
    end else if (bus.is_jal || (bus.is_branch && bus.taken)) begin
      target = pc_q + bus.imm;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    misalign_d  = misalign_q;
    trap_addr_d = trap_addr_q;
    case (state_q)
      ST_BOOT: begin
        // boot_q marks the first edge after reset release; the second
        // edge moves to FETCH so imem_req rises there.
        if (boot_q) begin
          state_d = ST_FETCH;
        end else begin
          boot_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.retire) begin
          valid_d = 1'b0;
          if (target[1]) begin
            misalign_d  = 1'b1;
            trap_addr_d = target;
            state_d     = ST_TRAP;
          end else begin
            pc_d    = target;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_q      <= 1'b0;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      trap_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.misalign    = misalign_q;
  assign bus.trap_addr   = trap_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed and randomized stimulus for pc_sequencer,
// checked against a next-PC reference model kept in the bench.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_trap_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic rt, input logic jalr, input logic jal,
                         input logic br, input logic tk,
                         input logic [31:0] imm, input logic [31:0] rs1);
    bus.retire    = rt;
    bus.is_jalr   = jalr;
    bus.is_jal    = jal;
    bus.is_branch = br;
    bus.taken     = tk;
    bus.imm       = imm;
    bus.rs1       = rs1;
  endtask

  // Starts and ends at a falling edge; the DUT must be in the fetch phase.
  task automatic do_fetch(input int stall, input logic [31:0] data);
    for (int i = 0; i < stall; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      chk("stall_req", 32'(bus.imem_req), 32'h1);
      chk("stall_addr", bus.imem_addr, m_pc);
      chk("stall_valid", 32'(bus.instr_valid), 32'h0);
      @(negedge clk);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = data;
    chk("fetch_req", 32'(bus.imem_req), 32'h1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    @(negedge clk);
    m_instr = data;
    bus.imem_ready = 1'($urandom_range(1, 0));
    bus.imem_rdata = $urandom;
    chk("exec_instr", bus.instr, m_instr);
    chk("exec_valid", 32'(bus.instr_valid), 32'h1);
    chk("exec_req", 32'(bus.imem_req), 32'h0);
    chk("exec_pc", bus.pc, m_pc);
    chk("exec_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
  endtask

  // Starts and ends at a falling edge; hold cycles precede the retire.
  task automatic do_exec(input int hold, input logic jalr, input logic jal,
                         input logic br, input logic tk,
                         input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    for (int i = 0; i < hold; i++) begin
      set_ctl(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom);
      bus.imem_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      chk("hold_instr", bus.instr, m_instr);
      chk("hold_valid", 32'(bus.instr_valid), 32'h1);
      chk("hold_pc", bus.pc, m_pc);
      chk("hold_req", 32'(bus.imem_req), 32'h0);
    end
    if (jalr)                   t = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jal || (br && tk)) t = m_pc + imm;
    else                        t = m_pc + 32'd4;
    set_ctl(1'b1, jalr, jal, br, tk, imm, rs1);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    if (t[1]) begin
      m_trap_addr = t;
      chk("trap_flag", 32'(bus.misalign), 32'h1);
      chk("trap_addr", bus.trap_addr, m_trap_addr);
      chk("trap_pc", bus.pc, m_pc);
      chk("trap_valid", 32'(bus.instr_valid), 32'h0);
      chk("trap_req", 32'(bus.imem_req), 32'h0);
    end else begin
      m_pc = t;
      chk("next_pc", bus.pc, m_pc);
      chk("next_valid", 32'(bus.instr_valid), 32'h0);
      chk("next_req", 32'(bus.imem_req), 32'h1);
      chk("next_misalign", 32'(bus.misalign), 32'h0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'h0);
    chk({tag, "_pc"}, bus.pc, 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_misalign"}, 32'(bus.misalign), 32'h0);
    chk({tag, "_trap_addr"}, bus.trap_addr, 32'h0);
  endtask

  initial begin
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    m_pc = 32'h0;
    m_instr = 32'h0;
    m_trap_addr = 32'h0;

    // reset and boot latency
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    chk("boot_edge1_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);

    // straight-line flow: fetch addresses 0,4,8,C
    for (int i = 0; i < 4; i++) begin
      do_fetch(0, 32'h1000_0000 + 32'(i));
      do_exec(0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    end

    // branch taken / not taken from 0x100
    do_fetch(0, 32'hA);
    do_exec(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0);
    chk("pc_is_100", bus.pc, 32'h100);
    do_fetch(0, 32'hB);
    do_exec(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0);
    chk("branch_taken_pc", bus.pc, 32'h0F0);
    do_fetch(1, 32'hC);
    do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    do_fetch(0, 32'hD);
    do_exec(2, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("branch_not_taken_pc", bus.pc, 32'h104);

    // jalr wins over a taken branch, bit 0 cleared
    do_fetch(0, 32'hE);
    chk("jalr_pre_plus4", bus.pc_plus4, 32'h108);
    do_exec(0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 32'h203);
    chk("jalr_pc", bus.pc, 32'h204);

    // randomized aligned control flow
    for (int i = 0; i < 24; i++) begin
      r_imm = $urandom & 32'hFFFF_FFFC;
      r_rs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 0));
      do_fetch($urandom_range(2, 0), $urandom);
      do_exec($urandom_range(2, 0), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), r_imm, r_rs1);
    end

    // stall at the top of the address space, then wrap to 0
    do_fetch(0, 32'h55);
    do_exec(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'hFFFF_FFF0);
    chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    do_fetch(3, 32'h66);
    do_exec(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", bus.pc, 32'h0);

    // asynchronous reset between edges while in EXEC
    do_fetch(0, 32'h77);
    do_exec(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    do_fetch(0, 32'h88);
    #2;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    chk_reset_vals("async_reset_hold");
    rst_n = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m_pc = 32'h0;
    @(negedge clk);
    chk("reboot_edge1_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    do_fetch(0, 32'h99);

    // misaligned jal from 0x40 traps and stays trapped
    do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    do_fetch(0, 32'hAA);
    do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
    chk("trap_addr_46", bus.trap_addr, 32'h46);
    chk("trap_pc_40", bus.pc, 32'h40);
    for (int i = 0; i < 10; i++) begin
      set_ctl(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom);
      bus.imem_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      chk("trapped_misalign", 32'(bus.misalign), 32'h1);
      chk("trapped_addr", bus.trap_addr, m_trap_addr);
      chk("trapped_pc", bus.pc, m_pc);
      chk("trapped_req", 32'(bus.imem_req), 32'h0);
      chk("trapped_valid", 32'(bus.instr_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; equals pc.
REQ-006 imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word; sampled only when imem_req && imem_ready.
REQ-008 instr  output  32  registered instruction presented to decode/execute.
REQ-009 instr_valid  output  1  instr is valid and awaiting retire.
REQ-010 pc  output  32  address of the current instruction.
REQ-011 pc_plus4  output  32  pc + 4 (link value for jal/jalr).
REQ-012 retire  input  1  execute stage has completed instr; the next-PC select inputs are valid this cycle.
REQ-013 is_branch  input  1  current instr is a conditional branch.
REQ-014 taken  input  1  branch condition result from the branch decoder.
REQ-015 is_jal  input  1  current instr is jal.
REQ-016 is_jalr  input  1  current instr is jalr.
REQ-017 imm  input  32  sign-extended immediate.
REQ-018 rs1  input  32  rs1 operand for jalr.
REQ-019 misalign  output  1  sticky trap flag: computed target not 4-byte aligned.
REQ-020 trap_addr  output  32  offending target address, valid while misalign=1.

Function
REQ-021 FSM states are BOOT, FETCH, EXEC and TRAP; BOOT is entered on reset and exits to FETCH after one cycle.
REQ-022 In FETCH, imem_req=1; on imem_ready=1, instr<=imem_rdata, instr_valid<=1, state<=EXEC; otherwise the block holds FETCH with imem_addr stable.
REQ-023 In EXEC, imem_req=0 and instr/pc are held until retire=1.
REQ-024 On retire, the target is selected by priority: is_jalr -> (rs1+imm) & ~32'h1; else is_jal -> pc+imm; else is_branch&&taken -> pc+imm; else pc+4.
REQ-025 All additions are 32-bit modulo 2^32; wrap-around is silent (32'hFFFF_FFFC + 4 = 32'h0).
REQ-026 If target[1]=1, the block SHALL set misalign<=1, trap_addr<=target, instr_valid<=0, state<=TRAP, leaving pc unchanged.
REQ-027 Otherwise, on retire: pc<=target, instr_valid<=0, state<=FETCH; the minimum fetch-to-fetch spacing is 2 cycles (FETCH, EXEC).
REQ-028 taken is ignored when is_branch=0; retire is ignored outside EXEC.
REQ-029 imem_ready is ignored when imem_req=0.
REQ-030 TRAP is terminal: imem_req=0 and instr_valid=0; only rst_n exits it.
REQ-031 pc_plus4 is combinational from pc and valid in every state.

Reset
REQ-032 While rst_n=0: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0, trap_addr=0.
REQ-033 Reset asserted mid-fetch or mid-execute SHALL abort immediately, with no retire or fetch completion recorded.
REQ-034 After rst_n deasserts, the first imem_req SHALL rise on the second clock edge (BOOT then FETCH).

Verification
REQ-035 Sequential flow: RESET_PC=0, imem_ready always 1, retire each EXEC with no control flow -> imem_addr sequence 0,4,8,C and instr_valid toggling 0/1.
REQ-036 Branch: pc=0x100, is_branch=1, taken=1, imm=0xFFFF_FFF0 -> next pc=0xF0; same stimulus with taken=0 -> pc=0x104.
REQ-037 jalr: rs1=0x203, imm=1, is_jalr=1 with is_branch=1, taken=1 also set -> pc=0x204 (jalr wins and bit0 cleared); pc_plus4 before retire = old pc+4.
REQ-038 Misalign: pc=0x40, is_jal=1, imm=0x6 -> misalign=1, trap_addr=0x46, pc stays 0x40, imem_req remains 0 for 10 cycles, retire ignored.
REQ-039 Stall and wrap: pc=0xFFFF_FFFC, imem_ready held 0 for 3 cycles -> imem_addr stable and instr_valid=0; then ready and retire -> pc=0x0.
REQ-040 Async reset: assert rst_n=0 between edges while in EXEC -> all outputs reach their reset values before the next edge; after release, the first fetch is at RESET_PC.
